// File: rtl/escalonador_rr.sv
// Round-robin process scheduler: picks the next ready slot after the running one
// and hands its saved PC to the CPU through a switch_req/switch_ack handshake.
module escalonador_rr #(
    parameter int NPROC = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     quantum_over,
    input  logic                     enable,
    input  logic                     proc_exit,
    input  logic                     proc_create,
    input  logic [$clog2(NPROC)-1:0] create_pid,
    input  logic [PC_W-1:0]          create_pc,
    input  logic [PC_W-1:0]          cur_pc,
    input  logic                     switch_ack,
    output logic                     switch_req,
    output logic [$clog2(NPROC)-1:0] next_pid,
    output logic [PC_W-1:0]          next_pc,
    output logic [$clog2(NPROC)-1:0] cur_pid,
    output logic                     quantum_reset,
    output logic                     idle
);

    localparam int PID_W = $clog2(NPROC);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SEL  = 2'd2;
    localparam logic [1:0] S_REQ  = 2'd3;

    logic [1:0]       state;
    logic [NPROC-1:0] ready;
    logic [PC_W-1:0]  pc_table [NPROC];

    logic             hit;
    logic [PID_W-1:0] hit_pid;
    logic             create_ok;
    logic             preempt;
    logic             leave_run;

    // A slot being rescheduled may not be overwritten while it owns the CPU.
    assign create_ok = proc_create && !(state != S_IDLE && create_pid == cur_pid);
    assign leave_run = (state == S_RUN) && (proc_exit || (quantum_over && enable));
    assign preempt   = (state == S_RUN) && !proc_exit && quantum_over && enable;

    // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_pid = cur_pid;
        // Offset NPROC truncates to zero, so the running slot is examined last.
        for (int i = 1; i <= NPROC; i++) begin
            if (!hit && ready[cur_pid + PID_W'(i)]) begin
                hit     = 1'b1;
                hit_pid = cur_pid + PID_W'(i);
            end
        end
    end

    // NOTE: the PC table is small and must read back as zero after reset, so it is reset
    // like ordinary flops rather than inferred as a RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready <= '0;
            for (int i = 0; i < NPROC; i++) begin
                pc_table[i] <= '0;
            end
        end else begin
            if (state == S_RUN && proc_exit) begin
                ready[cur_pid] <= 1'b0;
            end
            if (preempt) begin
                pc_table[cur_pid] <= cur_pc;
            end
            if (create_ok) begin
                ready[create_pid]    <= 1'b1;
                pc_table[create_pid] <= create_pc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, which is what makes a same-cycle create invisible to the search.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            cur_pid       <= '0;
            next_pid      <= '0;
            next_pc       <= '0;
            quantum_reset <= 1'b0;
        end else begin
            quantum_reset <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|ready) begin
                        state <= S_SEL;
                    end
                end
                S_RUN: begin
                    if (leave_run) begin
                        state <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (hit) begin
                        next_pid <= hit_pid;
                        next_pc  <= pc_table[hit_pid];
                        state    <= S_REQ;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (switch_ack) begin
                        cur_pid       <= next_pid;
                        quantum_reset <= 1'b1;
                        state         <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Decoded from the state register so reset removes the request asynchronously.
    assign switch_req = (state == S_REQ);
    assign idle       = (state == S_IDLE);

endmodule

// File: tb/tb_escalonador_rr.sv
// Self-checking bench for escalonador_rr: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural scheduler model.
module tb_escalonador_rr;

    localparam int NPROC = 4;
    localparam int PC_W  = 32;
    localparam int PID_W = $clog2(NPROC);

    logic             clk;
    logic             reset;
    logic             quantum_over;
    logic             enable;
    logic             proc_exit;
    logic             proc_create;
    logic [PID_W-1:0] create_pid;
    logic [PC_W-1:0]  create_pc;
    logic [PC_W-1:0]  cur_pc;
    logic             switch_ack;
    logic             switch_req;
    logic [PID_W-1:0] next_pid;
    logic [PC_W-1:0]  next_pc;
    logic [PID_W-1:0] cur_pid;
    logic             quantum_reset;
    logic             idle;

    escalonador_rr #(.NPROC(NPROC), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .quantum_over(quantum_over), .enable(enable),
        .proc_exit(proc_exit), .proc_create(proc_create), .create_pid(create_pid),
        .create_pc(create_pc), .cur_pc(cur_pc), .switch_ack(switch_ack),
        .switch_req(switch_req), .next_pid(next_pid), .next_pc(next_pc),
        .cur_pid(cur_pid), .quantum_reset(quantum_reset), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the scheduler's phase, ready set, saved PCs and handshake data.
    typedef enum int {M_IDLE, M_RUN, M_SEL, M_REQ} m_phase_t;
    m_phase_t         m_phase;
    bit [NPROC-1:0]   m_ready;
    logic [PC_W-1:0]  m_pc [NPROC];
    int               m_cur;
    int               m_nxt;
    logic [PC_W-1:0]  m_npc;
    bit               m_qrs;

    function automatic int rr_pick(int from);
        for (int k = 1; k <= NPROC; k++) begin
            if (m_ready[(from + k) % NPROC]) return (from + k) % NPROC;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        m_ready = '0;
        for (int i = 0; i < NPROC; i++) m_pc[i] = '0;
        m_cur = 0;
        m_nxt = 0;
        m_npc = '0;
        m_qrs = 1'b0;
    endtask

    task automatic model_step();
        m_phase_t ph;
        int       cur0;
        int       pick;
        ph   = m_phase;
        cur0 = m_cur;
        m_qrs = 1'b0;
        case (ph)
            M_IDLE: if (m_ready != 0) m_phase = M_SEL;
            M_RUN: begin
                if (proc_exit) begin
                    m_ready[m_cur] = 1'b0;
                    m_phase = M_SEL;
                end else if (quantum_over && enable) begin
                    m_pc[m_cur] = cur_pc;
                    m_phase = M_SEL;
                end
            end
            M_SEL: begin
                pick = rr_pick(m_cur);
                if (pick < 0) m_phase = M_IDLE;
                else begin
                    m_nxt = pick;
                    m_npc = m_pc[pick];
                    m_phase = M_REQ;
                end
            end
            M_REQ: begin
                if (switch_ack) begin
                    m_cur = m_nxt;
                    m_qrs = 1'b1;
                    m_phase = M_RUN;
                end
            end
            default: m_phase = M_IDLE;
        endcase
        if (proc_create && !(ph != M_IDLE && int'(create_pid) == cur0)) begin
            m_ready[create_pid] = 1'b1;
            m_pc[create_pid] = create_pc;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("switch_req", switch_req, m_phase == M_REQ);
            check("idle", idle, m_phase == M_IDLE);
            check("cur_pid", cur_pid, m_cur);
            check("quantum_reset", quantum_reset, m_qrs);
            if (m_phase == M_REQ) begin
                check("next_pid", next_pid, m_nxt);
                check("next_pc", next_pc, m_npc);
            end
        end
    end

    // Inputs change just after the falling edge; outputs are compared on the falling edge.
    task automatic step(bit qo, bit ex, bit cr, int cpid, logic [PC_W-1:0] cpc, bit ack);
        quantum_over = qo;
        proc_exit    = ex;
        proc_create  = cr;
        create_pid   = PID_W'(cpid);
        create_pc    = cpc;
        switch_ack   = ack;
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        model_reset();
        #1 check("rst_async_switch_req", switch_req, 1'b0);
        idle_step();
        #2 reset = 1'b1;
    endtask

    task automatic preempt_chk(string tag, int exp_pid, logic [PC_W-1:0] exp_pc);
        step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
        idle_step();
        check({tag, "_req"}, switch_req, 1'b1);
        check({tag, "_pid"}, next_pid, exp_pid);
        check({tag, "_pc"}, next_pc, exp_pc);
        step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        check({tag, "_qrs"}, quantum_reset, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        cur_pc = '0;
        quantum_over = 1'b0; proc_exit = 1'b0; proc_create = 1'b0;
        create_pid = '0; create_pc = '0; switch_ack = 1'b0;
        #1 reset = 1'b0;
        model_reset();
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_switch_req", switch_req, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_cur_pid", cur_pid, 0);
        check("rst_next_pid", next_pid, 0);
        check("rst_next_pc", next_pc, 0);
        check("rst_qrs", quantum_reset, 1'b0);
        #2 reset = 1'b1;

        // First process: create, select, request, acknowledge.
        step(1'b0, 1'b0, 1'b1, 0, 32'h100, 1'b0);
        idle_step();
        idle_step();
        check("first_req", switch_req, 1'b1);
        check("first_pid", next_pid, 0);
        check("first_pc", next_pc, 32'h100);
        step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        check("first_qrs", quantum_reset, 1'b1);
        check("first_cur", cur_pid, 0);
        check("first_idle", idle, 1'b0);
        idle_step();
        check("first_qrs_pulse", quantum_reset, 1'b0);

        // Rotation over slots 0,1,2 with PC save and wrap back to 0.
        step(1'b0, 1'b0, 1'b1, 1, 32'h200, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2, 32'h300, 1'b0);
        cur_pc = 32'h144;
        preempt_chk("rot1", 1, 32'h200);
        cur_pc = 32'h244;
        preempt_chk("rot2", 2, 32'h300);
        cur_pc = 32'h344;
        preempt_chk("rot_wrap", 0, 32'h144);

        // Sole ready process resumes itself with its own saved PC.
        async_reset();
        step(1'b0, 1'b0, 1'b1, 3, 32'h3000, 1'b0);
        idle_step();
        idle_step();
        check("solo_first_pid", next_pid, 3);
        step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        cur_pc = 32'h3abc;
        preempt_chk("solo", 3, 32'h3abc);

        // Exit beats a simultaneous quantum expiry; last exit leaves the scheduler idle.
        step(1'b0, 1'b0, 1'b1, 1, 32'h1000, 1'b0);
        cur_pc = 32'hdead;
        step(1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
        idle_step();
        check("exit_pid", next_pid, 1);
        check("exit_pc", next_pc, 32'h1000);
        step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        check("exit_cur", cur_pid, 1);
        step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
        idle_step();
        check("drain_idle", idle, 1'b1);
        check("drain_req", switch_req, 1'b0);
        idle_step();
        check("drain_req_hold", switch_req, 1'b0);

        // Preemption masked, then an unacknowledged request must hold steady.
        step(1'b0, 1'b0, 1'b1, 2, 32'h2222, 1'b0);
        idle_step();
        idle_step();
        check("mask_pid", next_pid, 2);
        step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        enable = 1'b0;
        repeat (3) begin
            step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
            idle_step();
            check("masked_no_req", switch_req, 1'b0);
        end
        enable = 1'b1;
        step(1'b0, 1'b0, 1'b1, 0, 32'h0aaa, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
        idle_step();
        repeat (5) begin
            check("hold_req", switch_req, 1'b1);
            check("hold_pid", next_pid, 0);
            check("hold_pc", next_pc, 32'h0aaa);
            check("hold_qrs", quantum_reset, 1'b0);
            idle_step();
        end

        // Reset in the middle of a request drops it at once and empties the ready set.
        #2 reset = 1'b0;
        model_reset();
        #1 check("midreq_req", switch_req, 1'b0);
        check("midreq_idle", idle, 1'b1);
        idle_step();
        #2 reset = 1'b1;
        repeat (3) idle_step();
        check("midreq_empty", idle, 1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                cur_pc = $urandom;
                enable = ($urandom_range(0, 7) != 0);
                step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 4) == 0, int'($urandom_range(0, NPROC - 1)),
                     $urandom, $urandom_range(0, 2) == 0);
            end
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
